// File: rtl/epc_serializer.sv
// PC+EPC backscatter serializer: shifts the stored word out MSB-first on epcclk after start.
// Optional CRC-16 trailer (poly 0x1021, preset 0xFFFF, complemented) is compiled in with EPC_CRC16_EN.
//
// state | meaning
// IDLE  | after reset, no transfer yet
// DATA  | emitting shift[index]
// CRC   | emitting the complemented CRC-16 (EPC_CRC16_EN only)
// DONE  | frame complete, waiting for start
module epc_serializer #(
    parameter int                  EPC_BITS = 112,
    parameter logic [EPC_BITS-1:0] EPC_INIT = 112'h3000aabbccddeeff012345678910
) (
    input  logic                epcclk,
    input  logic                reset,
    input  logic                start,
    input  logic                wr_en,
    input  logic [EPC_BITS-1:0] wr_data,
    output logic                epcbitout,
    output logic                epcvalid,
    output logic                epcdone,
    output logic [7:0]          bitsleft
);

`ifdef EPC_CRC16_EN
    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;
`endif

    localparam logic [6:0] IDX_MAX = 7'(EPC_BITS - 1);

    state_t              state, state_n;
    logic [EPC_BITS-1:0] stored;
    logic [EPC_BITS-1:0] shift, shift_n;
    logic [6:0]          index, index_n;
    logic [127:0]        shift_ext;
    logic                data_bit;

    // Widened copy so the 7-bit index addresses it without a width mismatch.
    assign shift_ext = 128'(shift);
    assign data_bit  = shift_ext[index];

`ifdef EPC_CRC16_EN
    logic [15:0] crc, crc_n;
    logic [3:0]  crcidx, crcidx_n;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    always_ff @(posedge epcclk or posedge reset) begin
        if (reset) begin
            stored <= EPC_INIT;
        end else if (wr_en) begin
            stored <= wr_data;
        end
    end

    always_ff @(posedge epcclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shift  <= '0;
            index  <= '0;
`ifdef EPC_CRC16_EN
            crc    <= 16'hFFFF;
            crcidx <= '0;
`endif
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            index  <= index_n;
`ifdef EPC_CRC16_EN
            crc    <= crc_n;
            crcidx <= crcidx_n;
`endif
        end
    end

    // start wins in every state: a transfer in progress is abandoned and reloaded.
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        index_n  = index;
`ifdef EPC_CRC16_EN
        crc_n    = crc;
        crcidx_n = crcidx;
`endif
        if (start) begin
            state_n  = DATA;
            shift_n  = stored;
            index_n  = IDX_MAX;
`ifdef EPC_CRC16_EN
            crc_n    = 16'hFFFF;
            crcidx_n = 4'd15;
`endif
        end else begin
            case (state)
                DATA: begin
`ifdef EPC_CRC16_EN
                    crc_n = crc_step(crc, data_bit);
                    if (index == 7'd0) state_n = CRC;
                    else               index_n = index - 7'd1;
`else
                    if (index == 7'd0) state_n = DONE;
                    else               index_n = index - 7'd1;
`endif
                end
`ifdef EPC_CRC16_EN
                CRC: begin
                    if (crcidx == 4'd0) state_n  = DONE;
                    else                crcidx_n = crcidx - 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        epcbitout = 1'b0;
        epcvalid  = 1'b0;
        epcdone   = 1'b0;
        bitsleft  = 8'd0;
        case (state)
            DATA: begin
                epcvalid  = 1'b1;
                epcbitout = data_bit;
`ifdef EPC_CRC16_EN
                bitsleft  = {1'b0, index} + 8'd17;
`else
                bitsleft  = {1'b0, index} + 8'd1;
`endif
            end
`ifdef EPC_CRC16_EN
            CRC: begin
                epcvalid  = 1'b1;
                epcbitout = ~crc[crcidx];
                bitsleft  = {4'd0, crcidx} + 8'd1;
            end
`endif
            default: epcdone = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_epc_serializer.sv
// Self-checking bench for epc_serializer: a vector table on a 16-bit instance plus
// hand-written multi-cycle sequences on the default 112-bit instance.
module tb_epc_serializer;

`ifdef EPC_CRC16_EN
    localparam int FRAME = 128;
    localparam int CRCX  = 16;
`else
    localparam int FRAME = 112;
    localparam int CRCX  = 0;
`endif
    localparam logic [111:0] EXP = 112'h3000aabbccddeeff012345678910;

    logic         epcclk, reset;
    logic         start, wr_en;
    logic [111:0] wr_data;
    logic         epcbitout, epcvalid, epcdone;
    logic [7:0]   bitsleft;
    logic         start16, wr_en16;
    logic [15:0]  wr_data16;
    logic         bitout16, valid16, done16;
    logic [7:0]   left16;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rx_crc;

    epc_serializer dut (
        .epcclk(epcclk), .reset(reset), .start(start), .wr_en(wr_en), .wr_data(wr_data),
        .epcbitout(epcbitout), .epcvalid(epcvalid), .epcdone(epcdone), .bitsleft(bitsleft)
    );

    epc_serializer #(.EPC_BITS(16), .EPC_INIT(16'h1234)) dut16 (
        .epcclk(epcclk), .reset(reset), .start(start16), .wr_en(wr_en16), .wr_data(wr_data16),
        .epcbitout(bitout16), .epcvalid(valid16), .epcdone(done16), .bitsleft(left16)
    );

    initial epcclk = 1'b0;
    always #5 epcclk = ~epcclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge epcclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        rx_crc = 16'hFFFF;
    endtask

    // Checks data bits from..to of word w; advances one edge before every bit except bit 0.
    task automatic check_bits(input logic [111:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (i != 0) tick();
            chk("data_valid", 32'(epcvalid), 32'd1);
            chk("data_done", 32'(epcdone), 32'd0);
            chk("data_bitsleft", 32'(bitsleft), 32'(FRAME - i));
            chk("data_bit", 32'(epcbitout), 32'(w[111 - i]));
            rx_crc = crc_upd(rx_crc, epcbitout);
        end
    endtask

    task automatic finish_frame();
`ifdef EPC_CRC16_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("crc_valid", 32'(epcvalid), 32'd1);
            chk("crc_bitsleft", 32'(bitsleft), 32'(16 - k));
            rx_crc = crc_upd(rx_crc, epcbitout);
        end
        chk("crc_residue", 32'(rx_crc), 32'h1D0F);
`endif
        tick();
        chk("end_done", 32'(epcdone), 32'd1);
        chk("end_valid", 32'(epcvalid), 32'd0);
        chk("end_bitsleft", 32'(bitsleft), 32'd0);
        chk("end_bit", 32'(epcbitout), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bit"}, 32'(epcbitout), 32'd0);
        chk({tag, "_valid"}, 32'(epcvalid), 32'd0);
        chk({tag, "_done"}, 32'(epcdone), 32'd1);
        chk({tag, "_bitsleft"}, 32'(bitsleft), 32'd0);
    endtask

    typedef struct {
        logic        start;
        logic        wr_en;
        logic [15:0] wr_data;
        logic        b;
        logic        valid;
        logic        done;
        logic [7:0]  left;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic w, input logic [15:0] d,
                                input logic b, input logic v, input logic dn, input int l);
        vec_t r;
        r.start = s; r.wr_en = w; r.wr_data = d;
        r.b = b; r.valid = v; r.done = dn; r.left = 8'(l);
        vecs.push_back(r);
    endfunction

    initial begin
        logic [15:0]  p1, p2;
        logic [111:0] w_alt, ones;
        p1    = 16'b1010_0101_1100_0011;
        p2    = 16'h0F0F;
        w_alt = {7{16'h5a3c}};
        ones  = '1;

        // Table for the 16-bit instance: write, send, same-edge write+start, restart.
        add(1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 16'h0000, p1[15], 1'b1, 1'b0, 16 + CRCX);
        for (int k = 1; k < 16; k++) add(1'b0, 1'b0, 16'h0000, p1[15 - k], 1'b1, 1'b0, 16 - k + CRCX);
`ifndef EPC_CRC16_EN
        add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
`endif
        add(1'b1, 1'b1, 16'h0F0F, p1[15], 1'b1, 1'b0, 16 + CRCX);
        add(1'b0, 1'b0, 16'h0000, p1[14], 1'b1, 1'b0, 15 + CRCX);
        add(1'b1, 1'b0, 16'h0000, p2[15], 1'b1, 1'b0, 16 + CRCX);
        for (int k = 1; k < 16; k++) add(1'b0, 1'b0, 16'h0000, p2[15 - k], 1'b1, 1'b0, 16 - k + CRCX);
`ifndef EPC_CRC16_EN
        add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
`endif

        reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_data = '0;
        start16 = 1'b0; wr_en16 = 1'b0; wr_data16 = '0;
        rx_crc = 16'hFFFF;
        #12;
        check_reset_vals("reset");
        chk("reset16_done", 32'(done16), 32'd1);
        chk("reset16_valid", 32'(valid16), 32'd0);
        @(negedge epcclk);
        reset = 1'b0;
        tick();

        foreach (vecs[n]) begin
            start16   = vecs[n].start;
            wr_en16   = vecs[n].wr_en;
            wr_data16 = vecs[n].wr_data;
            tick();
            chk($sformatf("v%0d_bit", n), 32'(bitout16), 32'(vecs[n].b));
            chk($sformatf("v%0d_valid", n), 32'(valid16), 32'(vecs[n].valid));
            chk($sformatf("v%0d_done", n), 32'(done16), 32'(vecs[n].done));
            chk($sformatf("v%0d_bitsleft", n), 32'(left16), 32'(vecs[n].left));
        end
        start16 = 1'b0; wr_en16 = 1'b0;

        // Default frame after reset.
        pulse_start();
        check_bits(EXP, 0, 111);
        finish_frame();

        // Write of all ones mid-frame only affects the next frame.
        pulse_start();
        check_bits(EXP, 0, 50);
        wr_data = ones;
        wr_en   = 1'b1;
        check_bits(EXP, 51, 51);
        wr_en   = 1'b0;
        check_bits(EXP, 52, 111);
        finish_frame();
        pulse_start();
        check_bits(ones, 0, 111);
        finish_frame();
        wr_data = EXP;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;

        // Restart at bit 40: MSB again on the next cycle, no epcdone in between.
        pulse_start();
        check_bits(EXP, 0, 40);
        pulse_start();
        check_bits(EXP, 0, 111);
        finish_frame();

        // Asynchronous reset mid-frame restores outputs and the stored word.
        wr_data = w_alt;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        pulse_start();
        check_bits(w_alt, 0, 60);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge epcclk);
        reset = 1'b0;
        tick();
        check_reset_vals("postreset");
        pulse_start();
        check_bits(EXP, 0, 111);
        finish_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
